// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the fetch path: instruction width,
//               HALT opcode, the NOP encoding and the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_WIDTH  = 20;
    localparam int OPCODE_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_HALT = 5'b11111;
    localparam logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 20'b0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Request/response PC pair for a 1-cycle-latency instruction
//               memory. req_pc is the next address to issue, resp_pc is the
//               address whose data is on the memory bus this cycle.
//               Controls (load has priority over advance, neither = hold):
//                 i_load     : resp_pc <= i_load_addr, req_pc <= i_load_addr+1
//                 i_advance  : resp_pc <= req_pc,      req_pc <= req_pc+1
// Ports       : clk, rst (sync, active-high), i_load, i_load_addr, i_advance,
//               o_req_pc, o_resp_pc, o_resp_valid
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_req_pc,
    output logic [ADDR_WIDTH-1:0] o_resp_pc,
    output logic                  o_resp_valid
);

    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic                  r_resp_valid;

    // Increments wrap naturally modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc     <= '0;
            r_resp_pc    <= '0;
            r_resp_valid <= 1'b0;
        end else if (i_load) begin
            r_resp_pc    <= i_load_addr;
            r_req_pc     <= i_load_addr + 1'b1;
            r_resp_valid <= 1'b1;
        end else if (i_advance) begin
            r_resp_pc    <= r_req_pc;
            r_req_pc     <= r_req_pc + 1'b1;
            r_resp_valid <= 1'b1;
        end
    end

    assign o_req_pc     = r_req_pc;
    assign o_resp_pc    = r_resp_pc;
    assign o_resp_valid = r_resp_valid;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage. Generates the PC stream into a synchronous
//               instruction ROM and presents instruction_fetch/pc_mux_output
//               to the FetchDecode register. Honours decode stall, branch
//               redirect, and stops issuing after a HALT instruction.
// Ports       : clk, reset (sync, active-high)
//               stall, select_pc_mux, branch_address     - hazard/branch ctrl
//               imem_address (comb), imem_data            - instruction ROM
//               instruction_fetch, pc_mux_output,
//               fetch_valid, halted                       - to decode
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 10,
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   select_pc_mux,
    input  logic [PC_WIDTH-1:0]    branch_address,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction_fetch,
    output logic [PC_WIDTH-1:0]    pc_mux_output,
    output logic                   fetch_valid,
    output logic                   halted
);

    import cpu_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [ADDR_WIDTH-1:0] w_req_pc;
    logic [ADDR_WIDTH-1:0] w_resp_pc;
    logic                  w_resp_valid;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic                  w_advance;
    logic [ADDR_WIDTH-1:0] w_branch_addr;
    logic                  w_branch_take;
    logic                  w_halt_detect;

    // Only the low address bits select a ROM word; the rest are ignored.
    assign w_branch_addr = branch_address[ADDR_WIDTH-1:0];

    generate
        if (PC_WIDTH > ADDR_WIDTH) begin : g_branch_hi
            logic w_unused_branch_hi;
            assign w_unused_branch_hi = ^branch_address[PC_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    // Stall outranks branch: decode keeps the branch asserted until it moves.
    assign w_branch_take = select_pc_mux & ~stall;

    assign w_halt_detect = (r_state == RUN) && w_resp_valid && !stall &&
                           !select_pc_mux &&
                           (imem_data[INSTR_WIDTH-1 -: OPCODE_WIDTH] == OPCODE_HALT);

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fetch_pc_reg (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_load),
        .i_load_addr  (w_load_addr),
        .i_advance    (w_advance),
        .o_req_pc     (w_req_pc),
        .o_resp_pc    (w_resp_pc),
        .o_resp_valid (w_resp_valid)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT: w_next_state = RUN;
            RUN: begin
                if (w_branch_take) begin
                    w_next_state = RUN;
                end else if (w_halt_detect) begin
                    w_next_state = HALT;
                end
            end
            HALT: begin
                // A redirect out of HALT means the HALT was on a wrong path.
                if (w_branch_take) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = BOOT;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        imem_address      = w_resp_pc;
        instruction_fetch = INSTR_WIDTH'(NOP_INSTR);
        fetch_valid       = 1'b0;
        halted            = 1'b0;
        w_load            = 1'b0;
        w_load_addr       = w_branch_addr;
        w_advance         = 1'b0;
        case (r_state)
            BOOT: begin
                // Loading address 0 leaves resp_pc=0, req_pc=1, resp_valid=1.
                imem_address = '0;
                w_load       = 1'b1;
                w_load_addr  = '0;
            end
            RUN: begin
                fetch_valid = w_resp_valid;
                if (w_resp_valid) begin
                    instruction_fetch = imem_data;
                end
                if (stall) begin
                    // Re-read the held word so the outputs stay stable.
                    imem_address = w_resp_pc;
                end else if (select_pc_mux) begin
                    imem_address = w_branch_addr;
                    w_load       = 1'b1;
                end else if (w_halt_detect) begin
                    // Stop issuing; pc pair freezes on the HALT's address.
                    imem_address = w_resp_pc;
                end else begin
                    imem_address = w_req_pc;
                    w_advance    = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (w_branch_take) begin
                    imem_address = w_branch_addr;
                    w_load       = 1'b1;
                end
            end
            default: begin
                imem_address = '0;
            end
        endcase
    end

    assign pc_mux_output = PC_WIDTH'(w_resp_pc);

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit with a 16-word
//               ROM (ADDR_WIDTH=4) so wrap-around is reachable. Each scenario
//               lists per-cycle inputs with the output expected on the next
//               cycle; expectations go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW = 4;
    localparam int PW = 16;
    localparam int IW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          select_pc_mux;
    logic [PW-1:0] branch_address;
    logic [AW-1:0] imem_address;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instruction_fetch;
    logic [PW-1:0] pc_mux_output;
    logic          fetch_valid;
    logic          halted;

    logic [IW-1:0] rom [16];

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic          v;
        logic          h;
        logic [PW-1:0] pc;
        logic [IW-1:0] instr;
    } obs_t;

    typedef struct packed {
        logic          rst;
        logic          stall;
        logic          sel;
        logic [PW-1:0] baddr;
        logic          ca;      // also check imem_address this cycle
        logic [AW-1:0] addr;
        logic          v;       // expected outputs on the following cycle
        logic          h;
        logic [PW-1:0] pc;
    } step_t;

    obs_t sb[$];

    instruction_fetch_unit #(
        .ADDR_WIDTH  (AW),
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .select_pc_mux     (select_pc_mux),
        .branch_address    (branch_address),
        .imem_address      (imem_address),
        .imem_data         (imem_data),
        .instruction_fetch (instruction_fetch),
        .pc_mux_output     (pc_mux_output),
        .fetch_valid       (fetch_valid),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) imem_data <= rom[imem_address];

    function automatic step_t mk(input logic rst, input logic st, input logic sel,
                                 input logic [PW-1:0] baddr, input logic ca,
                                 input logic [AW-1:0] addr, input logic v,
                                 input logic h, input logic [PW-1:0] pc);
        step_t s;
        s.rst = rst; s.stall = st; s.sel = sel; s.baddr = baddr;
        s.ca = ca; s.addr = addr; s.v = v; s.h = h; s.pc = pc;
        return s;
    endfunction

    function automatic obs_t exp_of(input step_t s);
        obs_t e;
        e.v     = s.v;
        e.h     = s.h;
        e.pc    = s.pc;
        e.instr = s.v ? rom[s.pc[AW-1:0]] : '0;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.v = fetch_valid; o.h = halted; o.pc = pc_mux_output; o.instr = instruction_fetch;
        return o;
    endfunction

    task automatic test_reset();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL reset_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL reset[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 0, 0, 0, 1, 4, 1, 0, 4));
        s.push_back(mk(0, 1, 0, 0, 1, 4, 1, 0, 4));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 4));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 1, 5, 1, 0, 5));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 6));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL stall_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL stall[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 0, 0, 0,        1, 7, 1, 0, 7));
        s.push_back(mk(0, 0, 1, 16'd2,    1, 2, 1, 0, 2));
        s.push_back(mk(0, 0, 0, 0,        0, 0, 1, 0, 3));
        // Upper branch bits must be ignored: 0xFFF9 targets word 9.
        s.push_back(mk(0, 0, 1, 16'hFFF9, 1, 9, 1, 0, 9));
        s.push_back(mk(0, 0, 0, 0,        0, 0, 1, 0, 10));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL branch_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL branch[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    task automatic test_stall_branch();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 1, 1, 16'd1, 1, 10, 1, 0, 10));
        s.push_back(mk(0, 1, 1, 16'd1, 0, 0,  1, 0, 10));
        s.push_back(mk(0, 0, 1, 16'd1, 1, 1,  1, 0, 1));
        s.push_back(mk(0, 0, 0, 0,     0, 0,  1, 0, 2));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL stall_branch_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL stall_branch[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        step_t s[$];
        obs_t  got, want;
        rom[5] = {5'b11111, 15'h0ABC};
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5));   // HALT presented, valid
        s.push_back(mk(0, 1, 0, 0, 1, 5, 1, 0, 5));   // stalled: HALT held, not taken
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5));   // now halted
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5));
        s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 5));   // stall blocks the redirect
        s.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0));   // resume at 0
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 5));   // HALT presented again
        s.push_back(mk(0, 0, 1, 16'd8, 1, 8, 1, 0, 8)); // branch cancels it
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 9));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL halt_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            // While halted the frozen PC value is not part of the contract.
            if (want.h) got.pc = want.pc;
            if (got !== want)
                $display("FAIL halt[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
        rom[5] = 20'd6;
    endtask

    task automatic test_wrap();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 0, 1, 16'd14, 1, 14, 1, 0, 14));
        s.push_back(mk(0, 0, 0, 0,      1, 15, 1, 0, 15));
        s.push_back(mk(0, 0, 0, 0,      1, 0,  1, 0, 0));
        s.push_back(mk(0, 0, 0, 0,      1, 1,  1, 0, 1));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL wrap_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL wrap[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t s[$];
        obs_t  got, want;
        s.push_back(mk(0, 1, 0, 0,     0, 0, 1, 0, 1));
        s.push_back(mk(1, 1, 1, 16'd7, 0, 0, 0, 0, 0));  // reset beats stall+branch
        s.push_back(mk(0, 0, 0, 0,     1, 0, 1, 0, 0));
        s.push_back(mk(0, 0, 0, 0,     1, 1, 1, 0, 1));
        foreach (s[k]) begin
            reset = s[k].rst; stall = s[k].stall;
            select_pc_mux = s[k].sel; branch_address = s[k].baddr;
            sb.push_back(exp_of(s[k]));
            if (s[k].ca) begin
                #1; n_total++;
                if (imem_address !== s[k].addr)
                    $display("FAIL reset_mid_addr[%0d]: imem_address=%0d required %0d", k, imem_address, s[k].addr);
                else n_pass++;
            end
            @(negedge clk);
            got = observe(); want = sb.pop_front(); n_total++;
            if (got !== want)
                $display("FAIL reset_mid[%0d]: got v=%0b h=%0b pc=%0d ins=%h, required v=%0b h=%0b pc=%0d ins=%h",
                         k, got.v, got.h, got.pc, got.instr, want.v, want.h, want.pc, want.instr);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = IW'(i + 1);
        reset          = 1'b1;
        stall          = 1'b0;
        select_pc_mux  = 1'b0;
        branch_address = '0;

        test_reset();
        test_stall();
        test_branch();
        test_stall_branch();
        test_halt();
        test_wrap();
        test_reset_mid_stall();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
